nios_pio_in: RTL and testbench
==============================

# nios_pio_in

Parametrised Avalon-MM input PIO slave for the Nios system: samples a WIDTH-bit external input bus, exposes it on a 32-bit read port, latches per-bit edge events into a sticky edge-capture register and raises a maskable interrupt. It sits on the Nios data master's slave side next to the other PIO peripherals. It replaces the fixed 8-bit, data-only input port with configurable width, edge detection, an interrupt mask and an optional input synchroniser.

## Interface
- WIDTH, 8: input bus width, legal 1..32
- EDGE_TYPE, 0: edge detected, 0 = rising, 1 = falling, 2 = any
- IRQ_TYPE, 1: 0 = level (irq from sampled input), 1 = edge (irq from edge-capture)
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select, qualifies writes
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  external input bus, possibly asynchronous
- readdata  out  32  registered read data
- irq  out  1  interrupt request, active high

## Operation
- Register map: 0 = data (RO, sampled input q); 1 = direction (reads 0, writes ignored); 2 = irqmask (RW); 3 = edgecapture (read; write-1-to-clear per bit).
- Write accepted when chipselect=1 and write_n=0; writes to 0/1 ignored.
- Bits [31:WIDTH] read 0 on every address; writedata bits [31:WIDTH] ignored.
- Sampled input q: registered copy of in_port (SYNC_EN changes depth, see Configuration); q_d = q delayed one cycle.
- Edge vector: rising = q & ~q_d; falling = ~q & q_d; any = q ^ q_d, per EDGE_TYPE.
- edgecapture[i] next = edge[i] | (edgecapture[i] & ~clear[i]); clear = writedata on accepted write to address 3. Same-cycle set and clear: set wins.
- irq: IRQ_TYPE=1 -> |(edgecapture & irqmask); IRQ_TYPE=0 -> |(q & irqmask). Combinational from registers, no glitch paths from in_port.
- Reset: readdata, irqmask, edgecapture, q, q_d, synchroniser flops all 0; irq 0. Pending edges discarded on reset mid-operation.
- After reset q_d=0: an input held high produces a rising (or any) edge capture once q first samples it. This is required behaviour.

## Timing
- readdata updated every cycle, no read strobe: readdata at edge N+1 = register selected by address at edge N. Read latency 1.
- Without SYNC_EN: in_port stable before edge E0 -> q at E0, edgecapture bit set at E1, visible on readdata (address 3) after E2.
- With SYNC_EN: every step is one cycle later (q at E1, edgecapture at E2).
- irqmask write at edge E -> irq reflects new mask immediately after E.
- Clear write at E -> edgecapture bit 0 after E unless re-set same cycle; irq deasserts after E.

## Configuration
- NIOS_PIO_IN_SYNC_EN defined: in_port passes through a two-flop synchroniser before q (q two cycles behind in_port); safe for asynchronous pins.
- Undefined: single input register only (q one cycle behind in_port); for inputs already synchronous to clk.

## Structure
- Package nios_pio_pkg: address constants (PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3), EDGE_TYPE and IRQ_TYPE encodings.
- Sub-module nios_pio_sync: WIDTH-bit two-flop synchroniser with sync active-high reset, instantiated only under NIOS_PIO_IN_SYNC_EN.

## Test plan
- Reset then read address 0 with in_port=8'hA5 held -> readdata 32'h000000A5 (after sync latency), irq 0, edgecapture 8'hA5 for EDGE_TYPE=0.
- WIDTH=8, EDGE_TYPE=0: clear all, pulse in_port[3] 0->1->0 -> edgecapture 8'h08 held after pulse; irqmask 8'h08 -> irq 1; write 32'h08 to address 3 -> edgecapture 0, irq 0 next cycle.
- Same-cycle clear of bit 3 and new rising edge on bit 3 -> edgecapture[3] stays 1.
- EDGE_TYPE=2: toggle in_port[0] 0->1 and 1->0 with clear between -> both edges captured; EDGE_TYPE=1 captures only 1->0.
- IRQ_TYPE=0, irqmask 8'h01: in_port[0]=1 -> irq 1; in_port[0]=0 -> irq 0 after sampling latency, regardless of edgecapture.
- Write 32'hFFFFFFFF to address 2 with WIDTH=4 -> readdata 32'h0000000F; write address 1 -> reads 0; assert reset mid-capture -> all state 0 next cycle.

Source files
------------

// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios input PIO: register addresses and the
// EDGE_TYPE / IRQ_TYPE parameter encodings.
package nios_pio_pkg;

  typedef enum logic [1:0] {
    PIO_ADDR_DATA    = 2'd0,
    PIO_ADDR_DIR     = 2'd1,
    PIO_ADDR_IRQMASK = 2'd2,
    PIO_ADDR_EDGECAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/nios_pio_sync.sv
// WIDTH-bit two-flop synchroniser for asynchronous input pins.
// Synchronous active-high reset clears both stages.
module nios_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: state flops use non-blocking assignment so every stage samples
  // the pre-edge value of its neighbour regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nios_pio_in.sv
// Avalon-MM input PIO: sampled input, sticky edge capture, maskable irq.
// Define NIOS_PIO_IN_SYNC_EN to put a two-flop synchroniser in front of q.
module nios_pio_in
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qd_q, qd_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;
  logic             unused_wdata;

`ifdef NIOS_PIO_IN_SYNC_EN
  // The synchroniser's second stage is q itself: two cycles behind in_port.
  nios_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (q)
  );
`else
  logic [WIDTH-1:0] q_q, q_d;

  always_comb q_d = in_port;

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
`endif

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISING:  edge_vec = q & ~qd_q;
      EDGE_FALLING: edge_vec = ~q & qd_q;
      default:      edge_vec = q ^ qd_q;
    endcase
  end

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    qd_d       = q;
    mask_d     = mask_q;
    clear      = '0;
    readdata_d = '0;

    if (wr_en && pio_addr_e'(address) == PIO_ADDR_IRQMASK) mask_d = wdata;
    if (wr_en && pio_addr_e'(address) == PIO_ADDR_EDGECAP) clear  = wdata;

    // A new edge in the same cycle as its clear keeps the bit set.
    ec_d = edge_vec | (ec_q & ~clear);

    case (pio_addr_e'(address))
      PIO_ADDR_DATA:    readdata_d = 32'(q);
      PIO_ADDR_DIR:     readdata_d = '0;
      PIO_ADDR_IRQMASK: readdata_d = 32'(mask_q);
      PIO_ADDR_EDGECAP: readdata_d = 32'(ec_q);
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qd_q       <= '0;
      ec_q       <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      qd_q       <= qd_d;
      ec_q       <= ec_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  generate
    if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
      assign irq = |(ec_q & mask_q);
    end else begin : g_irq_level
      assign irq = |(q & mask_q);
    end
  endgenerate

endmodule

// File: tb/tb_nios_pio_in.sv
// Self-checking bench for nios_pio_in: four parameter variants share one bus,
// a history-based reference model is compared every cycle, plus literal checks.
module tb_nios_pio_in;

  localparam int NI = 4;
  localparam int CW [NI] = '{8, 8, 4, 32};
  localparam int CE [NI] = '{0, 2, 1, 2};
  localparam int CI [NI] = '{1, 1, 0, 1};
`ifdef NIOS_PIO_IN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        cs;
  logic        write_n;
  logic [31:0] wdata;
  logic [31:0] in_bus;
  logic [31:0] rd [NI];
  logic [NI-1:0] irqv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(1)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(wdata), .in_port(in_bus[7:0]), .readdata(rd[0]), .irq(irqv[0]));
  nios_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(wdata), .in_port(in_bus[7:0]), .readdata(rd[1]), .irq(irqv[1]));
  nios_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .IRQ_TYPE(0)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(wdata), .in_port(in_bus[3:0]), .readdata(rd[2]), .irq(irqv[2]));
  nios_pio_in #(.WIDTH(32), .EDGE_TYPE(2), .IRQ_TYPE(1)) u3 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs), .write_n(write_n),
    .writedata(wdata), .in_port(in_bus), .readdata(rd[3]), .irq(irqv[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] edge_of(input int et, input logic [31:0] cur, input logic [31:0] prev);
    case (et)
      0:       return cur & ~prev;
      1:       return ~cur & prev;
      default: return cur ^ prev;
    endcase
  endfunction

  // Reference model: input delay line plus per-variant register state.
  logic [31:0] m_s, m_q, m_qd;
  logic [31:0] m_ec [NI];
  logic [31:0] m_mask [NI];
  logic [31:0] m_rd [NI];

  initial begin
    m_s = '0; m_q = '0; m_qd = '0;
    for (int k = 0; k < NI; k++) begin
      m_ec[k] = '0; m_mask[k] = '0; m_rd[k] = '0;
    end
  end

  always @(posedge clk) begin
    logic [31:0] wm, clr, exp_irq;
    logic        wr;
    wr = cs && !write_n;
    for (int k = 0; k < NI; k++) begin
      wm = wmask(CW[k]);
      if (reset) begin
        m_ec[k] = '0; m_mask[k] = '0; m_rd[k] = '0;
      end else begin
        case (address)
          2'd0:    m_rd[k] = m_q & wm;
          2'd1:    m_rd[k] = '0;
          2'd2:    m_rd[k] = m_mask[k];
          default: m_rd[k] = m_ec[k];
        endcase
        clr = (wr && address == 2'd3) ? (wdata & wm) : '0;
        m_ec[k] = (edge_of(CE[k], m_q, m_qd) | (m_ec[k] & ~clr)) & wm;
        if (wr && address == 2'd2) m_mask[k] = wdata & wm;
      end
    end
    if (reset) begin
      m_s = '0; m_q = '0; m_qd = '0;
    end else begin
      m_qd = m_q;
      if (LAT == 2) begin
        m_q = m_s;
        m_s = in_bus;
      end else begin
        m_q = in_bus;
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_irq = (CI[k] == 1) ? 32'(|(m_ec[k] & m_mask[k]))
                             : 32'(|(m_q & wmask(CW[k]) & m_mask[k]));
      check($sformatf("model_rd[%0d]", k), rd[k], m_rd[k]);
      check($sformatf("model_irq[%0d]", k), 32'(irqv[k]), exp_irq);
    end
  end

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write_n = 1'b0; address = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; write_n = 1'b1; address = 2'd0;
    wdata = '0; in_bus = 32'h0000_00A5;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Held input after reset: data visible, rising edges captured from q_d=0.
    repeat (LAT + 1) @(negedge clk);
    check("rst_data_u0", rd[0], 32'h0000_00A5);
    check("rst_data_u2", rd[2], 32'h0000_0005);
    check("rst_irq_u0", 32'(irqv[0]), 32'h0);
    check("model_ec_pin", m_ec[0], 32'h0000_00A5);
    address = 2'd3;
    @(negedge clk);
    check("rst_ec_u0", rd[0], 32'h0000_00A5);
    check("rst_ec_u2", rd[2], 32'h0000_0000);

    // Pulse bit 3, then mask/clear behaviour.
    wr_reg(2'd3, 32'hFFFF_FFFF);
    in_bus = 32'h0000_00AD;
    @(negedge clk);
    in_bus = 32'h0000_00A5;
    repeat (LAT + 3) @(negedge clk);
    address = 2'd3;
    @(negedge clk);
    check("pulse_ec_u0", rd[0], 32'h0000_0008);
    check("pulse_ec_u2", rd[2], 32'h0000_0008);
    wr_reg(2'd2, 32'h0000_0008);
    check("mask_irq_u0", 32'(irqv[0]), 32'h1);
    check("mask_irq_u2", 32'(irqv[2]), 32'h0);
    wr_reg(2'd3, 32'h0000_0008);
    check("clr_irq_u0", 32'(irqv[0]), 32'h0);
    @(negedge clk);
    check("clr_ec_u0", rd[0], 32'h0000_0000);

    // Clear write lands in the same cycle as a new rising edge on bit 3.
    in_bus = 32'h0000_00AD;
    repeat (LAT) @(negedge clk);
    cs = 1'b1; write_n = 1'b0; address = 2'd3; wdata = 32'h0000_0008;
    @(negedge clk);
    cs = 1'b0; write_n = 1'b1;
    @(negedge clk);
    check("setwins_ec_u0", rd[0], 32'h0000_0008);
    check("setwins_irq_u0", 32'(irqv[0]), 32'h1);
    in_bus = 32'h0000_00A5;
    repeat (LAT + 1) @(negedge clk);

    // Level irq on the 4-bit variant follows the sampled input.
    wr_reg(2'd2, 32'h0000_0001);
    check("lvl_irq_hi_u2", 32'(irqv[2]), 32'h1);
    in_bus = 32'h0000_00A4;
    repeat (LAT) @(negedge clk);
    check("lvl_irq_lo_u2", 32'(irqv[2]), 32'h0);

    // Upper bits of writedata ignored; direction reads 0.
    wr_reg(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    @(negedge clk);
    check("mask_w4_u2", rd[2], 32'h0000_000F);
    check("mask_w32_u3", rd[3], 32'hFFFF_FFFF);
    wr_reg(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    @(negedge clk);
    check("dir_u0", rd[0], 32'h0000_0000);

    // Reset in the middle of edge activity clears everything.
    in_bus = 32'h0000_005A;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("midrst_rd[%0d]", k), rd[k], 32'h0);
      check($sformatf("midrst_irq[%0d]", k), 32'(irqv[k]), 32'h0);
    end

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_bus  = in_bus ^ ($urandom & $urandom & $urandom);
      cs      = 1'($urandom_range(0, 1));
      write_n = 1'($urandom_range(0, 1));
      address = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       wdata = 32'hFFFF_FFFF;
        1:       wdata = $urandom & $urandom;
        default: wdata = $urandom;
      endcase
      reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    reset = 1'b0; cs = 1'b0; write_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
